// File: rtl/data_proc_deadlock_monitor_gen.sv
// Deadlock/stall monitor for the data_proc dataflow instance and its AXIS ports.
// Filters raw block indications through a persistence threshold and keeps
// sticky diagnostics (block source snapshot, longest stall run).
module data_proc_deadlock_monitor_gen #(
    parameter int unsigned NUM_AXIS = 2,
    parameter int unsigned NUM_INST = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_AXIS-1:0]          axis_block_sigs,
    input  logic [NUM_INST-1:0]          inst_idle_sigs,
    input  logic [NUM_INST-1:0]          inst_block_sigs,
    input  logic [CNT_W-1:0]             thresh,
    input  logic                         clear,
    output logic                         block,
    output logic                         block_sticky,
    output logic [NUM_AXIS+NUM_INST-1:0] block_src,
    output logic [CNT_W-1:0]             run_cnt,
    output logic [CNT_W-1:0]             max_run
);

    localparam int unsigned SRC_W = NUM_AXIS + NUM_INST;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_BLOCK = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              raw;
    logic [CNT_W-1:0]  th;
    logic [CNT_W-1:0]  nxt;
    logic [CNT_W-1:0]  run_nxt;
    logic [CNT_W-1:0]  max_nxt;
    logic              block_nxt;
    logic              block_rise;
    logic              src_load;
    logic [SRC_W-1:0]  live_src;

    // Raw stall condition, effective threshold and saturating run arithmetic.
    always_comb begin
        raw      = (|axis_block_sigs) |
                   ((&(inst_block_sigs | inst_idle_sigs)) & (|inst_block_sigs));
        th       = (thresh == '0) ? CNT_W'(1) : thresh;
        nxt      = (run_cnt == CNT_MAX) ? CNT_MAX : run_cnt + CNT_W'(1);
        run_nxt  = raw ? nxt : '0;
        live_src = {inst_block_sigs, axis_block_sigs};
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and derived block/sticky/max controls.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (raw) begin
                    state_nxt = (th == CNT_W'(1)) ? S_BLOCK : S_COUNT;
                end
            end
            S_COUNT: begin
                if (!raw) begin
                    state_nxt = S_IDLE;
                end else if (nxt >= th) begin
                    state_nxt = S_BLOCK;
                end
            end
            S_BLOCK: begin
                if (!raw) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        block_nxt  = (state_nxt == S_BLOCK);
        block_rise = block_nxt & ~block;
        // A clear on the rise edge re-arms the snapshot, so it loads.
        src_load   = block_rise & (~block_sticky | clear);
        if (clear) begin
            max_nxt = run_nxt;
        end else begin
            max_nxt = (run_nxt > max_run) ? run_nxt : max_run;
        end
    end

    // Registered outputs: live block, run counters and sticky diagnostics.
    always_ff @(posedge clock) begin
        if (reset) begin
            block        <= 1'b0;
            block_sticky <= 1'b0;
            block_src    <= '0;
            run_cnt      <= '0;
            max_run      <= '0;
        end else begin
            block   <= block_nxt;
            run_cnt <= run_nxt;
            max_run <= max_nxt;
            if (block_rise) begin
                block_sticky <= 1'b1;
            end else if (clear) begin
                block_sticky <= 1'b0;
            end
            if (src_load) begin
                block_src <= live_src;
            end else if (clear) begin
                block_src <= '0;
            end
        end
    end

endmodule

// File: doc/data_proc_deadlock_monitor_gen.md
Name: data_proc_deadlock_monitor_gen

Overview:
Parametrised deadlock/stall monitor for the data_proc dataflow instance and its AXIS ports. It generalises the single-cycle block detector in three ways:
- any number of AXIS block lines and sub-instances;
- a programmable persistence threshold, so short back-pressure bursts are filtered out;
- a sticky diagnostic capture of the block source, plus a longest-stall counter.

It sits beside the data_proc top and feeds the status/debug register block.

Parameters:
NUM_AXIS, 2, number of AXIS block lines monitored
NUM_INST, 1, number of sub-instances with idle/block signals
CNT_W, 16, width of the threshold, run counter and max-run counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
axis_block_sigs  in  NUM_AXIS  per-AXIS-port blocked indication
inst_idle_sigs  in  NUM_INST  per-instance idle indication
inst_block_sigs  in  NUM_INST  per-instance blocked indication
thresh  in  CNT_W  required consecutive raw-block cycles; 0 is treated as 1
clear  in  1  single-cycle pulse; clears sticky, block_src and max_run
block  out  1  filtered block, live (non-sticky)
block_sticky  out  1  latched block, held until clear
block_src  out  NUM_AXIS+NUM_INST  snapshot {inst_block_sigs, axis_block_sigs} at the first block rise
run_cnt  out  CNT_W  current consecutive raw-block cycle count, saturating
max_run  out  CNT_W  longest run_cnt seen since reset/clear, saturating

Behaviour:
- Reset: block=0, block_sticky=0, block_src=0, run_cnt=0, max_run=0, FSM=S_IDLE. Reset asserted mid-operation aborts any count; reset has priority over clear and over every event.
- Combinational raw condition:
  - axis_hit = OR of axis_block_sigs.
  - inst_hit = (AND over i of (inst_block_sigs[i] | inst_idle_sigs[i])) & (OR of inst_block_sigs). Every instance is stalled or idle, and at least one is blocked.
  - raw = axis_hit | inst_hit.
- Effective threshold: th = (thresh==0) ? 1 : thresh. thresh is sampled every cycle; software must change it only while block_sticky=0 and raw=0.
- run_cnt:
  - On each edge with raw=1: run_cnt <= run_cnt+1, saturating at all-ones.
  - On each edge with raw=0: run_cnt <= 0.
- FSM states S_IDLE, S_COUNT, S_BLOCK, with nxt = run_cnt+1 saturated:
  - S_IDLE: raw=0 stays. raw=1 and th==1 goes to S_BLOCK. raw=1 and th>1 goes to S_COUNT.
  - S_COUNT: raw=0 goes to S_IDLE. raw=1 and nxt>=th goes to S_BLOCK. Otherwise stays.
  - S_BLOCK: raw=0 goes to S_IDLE. Otherwise stays.
- block is registered and equals (next state == S_BLOCK). It rises on the edge where raw has been sampled high for th consecutive edges. With th=1 that is 1-cycle latency from raw, the legacy behaviour. block falls on the first edge raw is sampled low.
- block_sticky: set on any edge where block goes 0->1; cleared by clear. Same-edge set and clear: set wins.
- block_src: loaded with the live {inst_block_sigs, axis_block_sigs} only on the edge where block_sticky goes 0->1. It is not overwritten while sticky is set; zeroed by clear unless the same edge sets sticky, in which case it loads.
- max_run: on each edge, max_run <= max(max_run, next run_cnt).
  - clear zeroes max_run; if raw=1 on the clear edge, max_run loads the next run_cnt instead.
  - clear does not affect run_cnt, block or the FSM.
- Saturation: run_cnt and max_run hold at 2^CNT_W-1. The FSM stays in S_BLOCK while raw persists; there is no wrap-around.
- NUM_INST=0 is not supported; tie instances idle=1, block=0 instead.

Test Plan:
1. Reset, thresh=1, axis_block_sigs=01 for 1 cycle -> block=1 exactly one cycle later, for 1 cycle; block_sticky=1; block_src=...01 (NUM_AXIS=2, NUM_INST=1: 3'b001); max_run=1.
2. thresh=5, raw pulses of 4 cycles separated by 1 low cycle, repeated 3 times -> block never rises; max_run=4; run_cnt returns to 0 between pulses.
3. thresh=5, axis_block_sigs=10 held 8 cycles -> block rises on the 5th edge, stays high 4 cycles, falls 1 edge after release; block_src=3'b010; run_cnt peaks at 8.
4. inst_idle=0, inst_block=1, axis=00 -> inst_hit triggers block (thresh=1). Then inst_block=0 with idle=0 -> no block.
5. clear pulsed on the same edge as a new block rise (sticky previously cleared) -> sticky=1 and block_src loaded. clear alone afterwards -> sticky=0, block_src=0, max_run=0 (raw=0).
6. CNT_W=4, thresh=0, raw held 20 cycles -> block after 1 edge; run_cnt and max_run saturate at 15. Reset asserted mid-run -> all outputs 0 on the next edge.
